// File: rtl/fifo_rr_arbiter_pkg.sv
// rtl/fifo_rr_arbiter_pkg.sv - shared state encoding, widths and clog2 helper for the round-robin FIFO arbiter
package fifo_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int DATA_W = 32;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// rtl/fifo_rr_arbiter_if.sv - source-side and downstream FWFT read port bundle of the arbiter
interface fifo_rr_arbiter_if #(
  parameter int N_SRC = 4
);
  import fifo_rr_arbiter_pkg::*;

  logic [N_SRC-1:0]        SRC_READ_NEXT;
  logic [N_SRC-1:0]        SRC_EMPTY;
  logic [DATA_W*N_SRC-1:0] SRC_DATA;
  logic                    FIFO_READ_NEXT_IN;
  logic                    FIFO_EMPTY_OUT;
  logic [DATA_W-1:0]       FIFO_DATA_OUT;

  modport master (
    output SRC_READ_NEXT,
    input  SRC_EMPTY,
    input  SRC_DATA,
    input  FIFO_READ_NEXT_IN,
    output FIFO_EMPTY_OUT,
    output FIFO_DATA_OUT
  );

  modport slave (
    input  SRC_READ_NEXT,
    output SRC_EMPTY,
    output SRC_DATA,
    output FIFO_READ_NEXT_IN,
    input  FIFO_EMPTY_OUT,
    input  FIFO_DATA_OUT
  );

endinterface

// File: rtl/fifo_rr_arbiter_rr_find_first.sv
// rtl/fifo_rr_arbiter_rr_find_first.sv - combinational circular first-set search starting at ptr
module rr_find_first
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int IDX_W = clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_SRC-1:0] exclude,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_SRC-1:0] masked;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  assign masked = req & ~exclude;

  // Candidates are visited ptr, ptr+1, ... wrapping at N_SRC, which need not be a power of two.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_SRC)) begin
        sum = sum - (IDX_W+1)'(N_SRC);
      end
      cand = sum[IDX_W-1:0];
      if (!found && masked[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin, burst-bounded merge of N FWFT sources into one FWFT read port
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(
  parameter  int N_SRC   = 4,
  parameter  int BURST_W = 16,
  localparam int IDX_W   = clog2(N_SRC)
) (
  input  logic               BUS_CLK,
  input  logic               BUS_RST_N,
  fifo_rr_arbiter_if.master  bus,
  input  logic [N_SRC-1:0]   ENABLE,
  input  logic [BURST_W-1:0] BURST_LEN,
  input  logic               ERR_CLR,
  output logic               GRANT_VALID,
  output logic [IDX_W-1:0]   GRANT_IDX,
  output logic               READ_ERROR
);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [N_SRC-1:0]   req;
  logic [N_SRC-1:0]   excl;
  logic [IDX_W-1:0]   g_plus1;
  logic [IDX_W-1:0]   arb_ptr;
  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  logic               active;
  logic               g_empty;
  logic               pop;
  logic               at_limit;
  logic               rel;
  logic [DATA_W-1:0]  src_words [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_words[i] = bus.SRC_DATA[DATA_W*i +: DATA_W];
  end

  assign req     = ENABLE & ~bus.SRC_EMPTY;
  assign g_plus1 = (g_q == IDX_W'(N_SRC-1)) ? '0 : g_q + IDX_W'(1);
  // While granted, re-arbitration starts after g and never picks g itself, so a release is a real hand-off.
  assign arb_ptr = (state_q == ST_GRANT) ? g_plus1 : ptr_q;
  assign excl    = (state_q == ST_GRANT) ? ({{(N_SRC-1){1'b0}}, 1'b1} << g_q) : '0;

  rr_find_first #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_find (
    .req     (req),
    .ptr     (arb_ptr),
    .exclude (excl),
    .found   (arb_found),
    .idx     (arb_idx)
  );

  // Holding reset low suppresses the combinational pop so a reset mid-burst loses no word.
  assign active   = (state_q == ST_GRANT) && BUS_RST_N;
  assign g_empty  = bus.SRC_EMPTY[g_q];
  assign pop      = active && bus.FIFO_READ_NEXT_IN && !g_empty;
  assign at_limit = (BURST_LEN != '0) && (cnt_q == BURST_LEN - BURST_W'(1));
  assign rel      = (state_q == ST_GRANT) && (g_empty || (pop && at_limit));

  always_comb begin
    bus.SRC_READ_NEXT  = '0;
    bus.FIFO_EMPTY_OUT = 1'b1;
    bus.FIFO_DATA_OUT  = '0;
    state_d            = state_q;
    ptr_d              = ptr_q;
    g_d                = g_q;
    cnt_d              = cnt_q;

    if (active) begin
      bus.FIFO_EMPTY_OUT     = g_empty;
      bus.FIFO_DATA_OUT      = src_words[g_q];
      bus.SRC_READ_NEXT[g_q] = pop;
    end

    if (state_q == ST_IDLE) begin
      if (arb_found) begin
        state_d = ST_GRANT;
        g_d     = arb_idx;
        cnt_d   = '0;
      end
    end else begin
      if (rel) begin
        ptr_d = g_plus1;
        if (arb_found) begin
          g_d   = arb_idx;
          cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (pop && !(&cnt_q)) begin
        cnt_d = cnt_q + BURST_W'(1);
      end
    end

    err_d = err_q;
    if (bus.FIFO_READ_NEXT_IN && bus.FIFO_EMPTY_OUT) begin
      err_d = 1'b1;
    end else if (ERR_CLR) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign GRANT_VALID = (state_q == ST_GRANT);
  assign GRANT_IDX   = g_q;
  assign READ_ERROR  = err_q;

endmodule
